// File: rtl/uart_rx_edge_sampler_pkg.sv
// Shared UART RX definitions: legal oversampling ratios, bit-count sizing
// and the three-sample majority vote used by the receive path.
package uart_rx_edge_sampler_pkg;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    // Frame positions are start, width data bits, parity and stop.
    function automatic int unsigned bit_count_w(input int unsigned data_bits);
        return $clog2(data_bits + 3);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_edge_sampler_bit_sampler.sv
// Mid-bit sampler: captures three consecutive S_Data samples around the
// centre of each bit and registers their majority with a one-cycle strobe.
module uart_rx_bit_sampler
    import uart_rx_edge_sampler_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_en,
    input  logic [PRESCALE_W-1:0] edge_count,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  s_data,
    output logic                  sampled,
    output logic                  sampled_bit
);

    logic [PRESCALE_W-1:0] half;
    logic                  at_s0;
    logic                  at_s1;
    logic                  at_s2;
    logic                  s0;
    logic                  s1;

    assign half  = prescale >> 1;
    assign at_s0 = (edge_count == half - PRESCALE_W'(2));
    assign at_s1 = (edge_count == half - PRESCALE_W'(1));
    assign at_s2 = (edge_count == half);

    // The third sample is voted straight from s_data so the result lands
    // in the edge_count == P/2+1 cycle together with the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0          <= 1'b0;
            s1          <= 1'b0;
            sampled     <= 1'b0;
            sampled_bit <= 1'b1;
        end else if (!s_en) begin
            s0          <= 1'b0;
            s1          <= 1'b0;
            sampled     <= 1'b0;
        end else begin
            sampled <= at_s2;
            if (at_s0) begin
                s0 <= s_data;
            end
            if (at_s1) begin
                s1 <= s_data;
            end
            if (at_s2) begin
                sampled_bit <= majority3(s0, s1, s_data);
            end
        end
    end

endmodule

// File: rtl/uart_rx_edge_sampler.sv
// UART RX timing front end: line synchroniser, oversampling edge counter,
// saturating bit counter and the mid-bit majority sampler.
module uart_rx_edge_sampler
    import uart_rx_edge_sampler_pkg::*;
#(
    parameter int width      = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic                          RX_IN,
    input  logic [PRESCALE_W-1:0]         Prescale,
    input  logic                          S_EN,
    output logic                          S_Data,
    output logic [PRESCALE_W-1:0]         edge_count,
    output logic [bit_count_w(width)-1:0] bit_count,
    output logic                          Last_edge,
    output logic                          sampled,
    output logic                          sampled_bit
);

    localparam int unsigned     BCW     = bit_count_w(width);
    localparam logic [BCW-1:0]  BIT_MAX = BCW'(width + 2);

    logic                  sync_meta;
    logic                  sync_out;
    logic                  s_en_q;
    logic                  enable_rise;
    logic                  wrap;
    logic [PRESCALE_W-1:0] p_reg;
    logic [PRESCALE_W-1:0] p_eff;

    assign S_Data = sync_out;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
        end else begin
            sync_meta <= RX_IN;
            sync_out  <= sync_meta;
        end
    end

    // On the enabling cycle the latch has not yet loaded, so the live input
    // stands in for it; afterwards Prescale is ignored until re-enable.
    assign enable_rise = S_EN && !s_en_q;
    assign p_eff       = enable_rise ? Prescale : p_reg;
    assign wrap        = (edge_count == p_eff - PRESCALE_W'(1));
    assign Last_edge   = S_EN && wrap;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            s_en_q <= 1'b0;
            p_reg  <= PRESCALE_W'(PRESCALE_8);
        end else begin
            s_en_q <= S_EN;
            if (enable_rise) begin
                p_reg <= Prescale;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (!S_EN) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (wrap) begin
            edge_count <= '0;
            if (bit_count != BIT_MAX) begin
                bit_count <= bit_count + BCW'(1);
            end
        end else begin
            edge_count <= edge_count + PRESCALE_W'(1);
        end
    end

    uart_rx_bit_sampler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_bit_sampler (
        .clk        (CLK),
        .rst        (Reset),
        .s_en       (S_EN),
        .edge_count (edge_count),
        .prescale   (p_eff),
        .s_data     (sync_out),
        .sampled    (sampled),
        .sampled_bit(sampled_bit)
    );

endmodule

// File: doc/uart_rx_edge_sampler.md
Name: uart_rx_edge_sampler

Overview:
- Timing front end of the UART receiver, directly upstream of the RX control FSM.
- Synchronises the raw serial line, runs the oversampling edge counter and the bit counter, and majority-votes each bit at mid-bit.
- Drives the FSM's S_Data, bit_count, sampled and Last_edge inputs, and the sampled bit value to the parity, start, stop and deserializer checkers.

Parameters:
- width, 8, data bits per frame; sizes bit_count.
- PRESCALE_W, 6, width of the Prescale input (supports oversampling of 8, 16, 32).

Ports:
- CLK  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- RX_IN  in  1  raw asynchronous serial line; idle high.
- Prescale  in  PRESCALE_W  oversampling ratio; legal values are 8, 16, 32.
- S_EN  in  1  sampler/counter enable from the RX control FSM.
- S_Data  out  1  synchronised serial line (2-flop synchroniser output).
- edge_count  out  PRESCALE_W  oversampling tick index within the current bit.
- bit_count  out  $clog2(width+3)  index of the current bit in the frame.
- Last_edge  out  1  high while edge_count is the last tick of the bit.
- sampled  out  1  one-cycle pulse when sampled_bit is updated.
- sampled_bit  out  1  majority-voted value of the current bit.

Behaviour:
- Reset (async, active-high):
  - Synchroniser flops = 1, so S_Data = 1.
  - edge_count = 0, bit_count = 0, sampled = 0, sampled_bit = 1.
  - Sample registers = 0; latched prescale P = 8.
- Synchroniser:
  - RX_IN passes through 2 flops. S_Data lags RX_IN by 2 CLK edges.
  - All sampling uses S_Data.
- Prescale latch: P is captured from Prescale on the S_EN rising edge (S_EN = 1 while the previous cycle's S_EN was 0). Changing Prescale mid-frame has no effect.
- S_EN = 0:
  - Next edge: edge_count = 0, bit_count = 0, sampled = 0, sample registers cleared.
  - sampled_bit holds its value.
- S_EN = 1:
  - edge_count increments each cycle and wraps from P-1 to 0.
  - On the wrap, bit_count increments, saturating at width+2.
- Bit numbering: start bit = 0, data bits = 1..width, then parity (if enabled) and stop bits.
- Last_edge is combinational: S_EN && (edge_count == P-1).
- Mid-bit samples of S_Data:
  - s0 at edge_count = P/2-2, s1 at P/2-1, s2 at P/2.
  - In the cycle with edge_count = P/2+1: sampled = 1 for exactly one cycle, and sampled_bit = majority(s0, s1, s2), registered together with sampled.
  - sampled_bit holds until the next sampled pulse.
- Ordering: sampled always precedes Last_edge within a bit, since P/2+1 < P-1 for P ≥ 8.
- S_EN falling mid-bit: counters clear on the next edge and no sampled pulse is produced for the aborted bit. Re-enabling starts at edge_count = 0.
- Reset asserted mid-frame: all state returns to reset values immediately, independent of the clock.
- Prescale values other than 8, 16 or 32 are unsupported. The block must not lock up: the counter still wraps at P-1 for any P ≥ 4.

Decomposition:
- Shared uart_rx package holds:
  - PRESCALE_8, PRESCALE_16, PRESCALE_32 constants.
  - A majority3 function.
  - The bit-count width expression, shared with the RX control FSM and the deserializer.
- One natural sub-module, uart_rx_bit_sampler: takes edge_count, P and S_Data; produces sampled and sampled_bit.
- Counters and the synchroniser stay in the top module.

Test Plan:
- Reset, RX_IN = 1, S_EN = 0 -> S_Data = 1, edge_count = 0, bit_count = 0, sampled = 0, sampled_bit = 1; RX_IN = 0 observed on S_Data exactly 2 edges later.
- Prescale = 8, S_EN = 1 held for 24 cycles -> edge_count cycles 0..7 three times; Last_edge high at every edge_count = 7; bit_count goes 0→1→2→3; sampled pulses at edge_count = 5 of each bit.
- Prescale = 16, S_Data held 0 except a single-cycle glitch to 1 at edge_count = 7 -> sampled at edge_count = 9 with sampled_bit = 0 (majority rejects glitch).
- Prescale = 8, full frame of width = 8 data 0xA5 LSB-first plus parity and stop -> sampled_bit sequence 0,1,0,1,0,0,1,0,1,parity,1; bit_count reaches 10 then saturates at 10 if S_EN is held.
- Change Prescale from 16 to 8 mid-frame -> wrap stays at 15 until S_EN drops and rises again; then wrap at 7.
- Reset asserted at bit_count = 4, edge_count = 3 (asynchronously, between clock edges) -> all outputs return to reset values before the next CLK edge; S_EN falling at edge_count = 2 -> next edge edge_count = 0, bit_count = 0, no sampled pulse.
